// File: rtl/lc3_pkg.sv
// rtl/lc3_pkg.sv - shared FSM encoding, MMIO address map and decode helper for memory_responder
`timescale 1ns/1ps
package lc3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_READY = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;

  // Display is always ready to accept a character.
  localparam logic [15:0] DSR_READY = 16'h8000;

  function automatic logic is_mmio(input logic [15:0] addr);
    return (addr == KBSR_ADDR) || (addr == KBDR_ADDR) ||
           (addr == DSR_ADDR)  || (addr == DDR_ADDR);
  endfunction

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - synchronous single-port 16-bit RAM of depth 2^ADDR_W, read-first
`timescale 1ns/1ps
module mem_array
  import lc3_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata
);

  logic [15:0] mem_q [0:(1<<ADDR_W)-1];

  // One port: write and registered read share the enable; contents are not reset.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_q[addr] <= wdata;
      end
      rdata <= mem_q[addr];
    end
  end

endmodule

// File: rtl/memory_responder.sv
// rtl/memory_responder.sv - fixed-latency memory responder; MEMORY_RESPONDER_MMIO_EN adds keyboard/display registers
`timescale 1ns/1ps
module memory_responder
  import lc3_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mio_en,
  input  logic        r_w,
  input  logic [15:0] mar,
  input  logic [15:0] mdr_in,
  output logic [15:0] mem_data,
  output logic        r,
  input  logic        kb_valid,
  input  logic [7:0]  kb_char,
  output logic        dsp_valid,
  output logic [7:0]  dsp_char
);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] mar_q, mar_d;
  logic [15:0] mdr_q, mdr_d;
  logic        wr_q, wr_d;
  logic        r_q, r_d;

  // High on the edge that moves BUSY -> READY: writes commit and reads are sampled here.
  logic        access_done;
  logic        mmio_hit;
  logic        ram_en;
  logic        ram_we;
  logic [15:0] ram_rdata;
  logic [15:0] mmio_rdata;

  // Next-state logic: accept in IDLE, count down in BUSY, pulse r in READY, wait for release in DONE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mar_d       = mar_q;
    mdr_d       = mdr_q;
    wr_d        = wr_q;
    r_d         = 1'b0;
    access_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mio_en) begin
          mar_d   = mar;
          mdr_d   = mdr_in;
          wr_d    = r_w;
          cnt_d   = 4'(LATENCY - 1);
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q == 4'd0) begin
          access_done = 1'b1;
          r_d         = 1'b1;
          state_d     = ST_READY;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_READY: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (!mio_en) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM, latched request and registered ready pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      mar_q   <= 16'h0000;
      mdr_q   <= 16'h0000;
      wr_q    <= 1'b0;
      r_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      wr_q    <= wr_d;
      r_q     <= r_d;
    end
  end

`ifdef MEMORY_RESPONDER_MMIO_EN
  logic        kbsr_q, kbsr_d;
  logic [7:0]  kbdr_q, kbdr_d;
  logic        dsp_valid_q, dsp_valid_d;
  logic [7:0]  dsp_char_q, dsp_char_d;
  logic [15:0] mmio_rdata_q, mmio_rdata_d;

  assign mmio_hit = is_mmio(mar_q);

  // Device registers: a KBDR read clears the ready flag, but a new keystroke in the same cycle wins.
  always_comb begin
    kbsr_d       = kbsr_q;
    kbdr_d       = kbdr_q;
    dsp_valid_d  = 1'b0;
    dsp_char_d   = dsp_char_q;
    mmio_rdata_d = mmio_rdata_q;
    if (access_done && !wr_q) begin
      case (mar_q)
        KBSR_ADDR: mmio_rdata_d = {kbsr_q, 15'h0000};
        KBDR_ADDR: mmio_rdata_d = {8'h00, kbdr_q};
        DSR_ADDR:  mmio_rdata_d = DSR_READY;
        default:   mmio_rdata_d = 16'h0000;
      endcase
      if (mar_q == KBDR_ADDR) begin
        kbsr_d = 1'b0;
      end
    end
    if (access_done && wr_q && (mar_q == DDR_ADDR)) begin
      dsp_valid_d = 1'b1;
      dsp_char_d  = mdr_q[7:0];
    end
    if (kb_valid) begin
      kbsr_d = 1'b1;
      kbdr_d = kb_char;
    end
  end

  // Device register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kbsr_q       <= 1'b0;
      kbdr_q       <= 8'h00;
      dsp_valid_q  <= 1'b0;
      dsp_char_q   <= 8'h00;
      mmio_rdata_q <= 16'h0000;
    end else begin
      kbsr_q       <= kbsr_d;
      kbdr_q       <= kbdr_d;
      dsp_valid_q  <= dsp_valid_d;
      dsp_char_q   <= dsp_char_d;
      mmio_rdata_q <= mmio_rdata_d;
    end
  end

  assign mmio_rdata = mmio_rdata_q;
  assign dsp_valid  = dsp_valid_q;
  assign dsp_char   = dsp_char_q;
`else
  logic unused_inputs;

  assign mmio_hit      = 1'b0;
  assign mmio_rdata    = 16'h0000;
  assign dsp_valid     = 1'b0;
  assign dsp_char      = 8'h00;
  assign unused_inputs = ^{kb_valid, kb_char, mar_q};
`endif

  assign ram_en = access_done && !mmio_hit;
  assign ram_we = ram_en && wr_q;

  mem_array #(
    .ADDR_W (ADDR_W)
  ) u_mem_array (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (mar_q[ADDR_W-1:0]),
    .wdata (mdr_q),
    .rdata (ram_rdata)
  );

  // Read data is only driven during the ready pulse of a read.
  always_comb begin
    mem_data = 16'h0000;
    if (r_q && !wr_q) begin
      mem_data = mmio_hit ? mmio_rdata : ram_rdata;
    end
  end

  assign r = r_q;

endmodule

// File: tb/tb_memory_responder.sv
// tb/tb_memory_responder.sv - directed self-checking bench for memory_responder
`timescale 1ns/1ps
module tb_memory_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mio_en;
  logic        r_w;
  logic [15:0] mar;
  logic [15:0] mdr_in;
  logic [15:0] mem_data;
  logic        r;
  logic        kb_valid;
  logic [7:0]  kb_char;
  logic        dsp_valid;
  logic [7:0]  dsp_char;

  int total = 0;
  int bad   = 0;

  int          acc_lat;
  logic [15:0] acc_data;
  int          acc_pulses;
  int          acc_leak;
  int          acc_dsp_cnt;
  logic [7:0]  acc_dsp_char;

  always #5 clk = ~clk;

  memory_responder #(
    .ADDR_W  (12),
    .LATENCY (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mio_en    (mio_en),
    .r_w       (r_w),
    .mar       (mar),
    .mdr_in    (mdr_in),
    .mem_data  (mem_data),
    .r         (r),
    .kb_valid  (kb_valid),
    .kb_char   (kb_char),
    .dsp_valid (dsp_valid),
    .dsp_char  (dsp_char)
  );

  // One access: request is scrambled right after acceptance; mio_en held for at least `hold` cycles.
  task automatic do_access(input logic w, input logic [15:0] a, input logic [15:0] d, input int hold);
    @(negedge clk);
    mio_en = 1'b1; r_w = w; mar = a; mdr_in = d;
    @(posedge clk); #1;
    mar = ~a; mdr_in = ~d; r_w = ~w;
    acc_lat = 0; acc_data = 16'hxxxx; acc_pulses = 0; acc_leak = 0;
    acc_dsp_cnt = 0; acc_dsp_char = 8'h00;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      if (r === 1'b1) begin
        acc_pulses++;
        if (acc_lat == 0) begin
          acc_lat  = i;
          acc_data = mem_data;
        end
      end else if (mem_data !== 16'h0000) begin
        acc_leak = 1;
      end
      if (dsp_valid === 1'b1) begin
        acc_dsp_cnt++;
        acc_dsp_char = dsp_char;
      end
      if (i >= hold && acc_lat != 0) mio_en = 1'b0;
    end
    mio_en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mio_en = 1'b0; r_w = 1'b0; mar = 16'h0; mdr_in = 16'h0;
    kb_valid = 1'b0; kb_char = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    total++; if (r !== 1'b0) begin bad++; $display("FAIL reset_r got=%b exp=0", r); end
    total++; if (mem_data !== 16'h0000) begin bad++; $display("FAIL reset_mem_data got=%h exp=0000", mem_data); end
    total++; if (dsp_valid !== 1'b0) begin bad++; $display("FAIL reset_dsp_valid got=%b exp=0", dsp_valid); end
    total++; if (dsp_char !== 8'h00) begin bad++; $display("FAIL reset_dsp_char got=%h exp=00", dsp_char); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    do_access(1'b1, 16'h0005, 16'h1234, 0);
    total++; if (acc_lat != 3) begin bad++; $display("FAIL wr_latency got=%0d exp=3", acc_lat); end
    total++; if (acc_pulses != 1) begin bad++; $display("FAIL wr_pulses got=%0d exp=1", acc_pulses); end
    do_access(1'b0, 16'h0005, 16'h0000, 0);
    total++; if (acc_lat != 3) begin bad++; $display("FAIL rd_latency got=%0d exp=3", acc_lat); end
    total++; if (acc_data !== 16'h1234) begin bad++; $display("FAIL rd_data got=%h exp=1234", acc_data); end
    total++; if (acc_leak != 0) begin bad++; $display("FAIL rd_data_while_r0 got=%0d exp=0", acc_leak); end
  endtask

  task automatic test_held_request();
    do_access(1'b1, 16'h0020, 16'h5A5A, 10);
    total++; if (acc_pulses != 1) begin bad++; $display("FAIL hold_pulses got=%0d exp=1", acc_pulses); end
    do_access(1'b0, 16'h0020, 16'h0000, 0);
    total++; if (acc_data !== 16'h5A5A) begin bad++; $display("FAIL hold_readback got=%h exp=5a5a", acc_data); end
  endtask

  task automatic test_alias();
    do_access(1'b1, 16'h1005, 16'hBEEF, 0);
    do_access(1'b0, 16'h0005, 16'h0000, 0);
    total++; if (acc_data !== 16'hBEEF) begin bad++; $display("FAIL alias_0005 got=%h exp=beef", acc_data); end
    do_access(1'b0, 16'hF005, 16'h0000, 0);
    total++; if (acc_data !== 16'hBEEF) begin bad++; $display("FAIL alias_f005 got=%h exp=beef", acc_data); end
  endtask

  task automatic test_reset_abort();
    int r_seen;
    do_access(1'b1, 16'h0010, 16'h0000, 0);
    @(negedge clk);
    mio_en = 1'b1; r_w = 1'b1; mar = 16'h0010; mdr_in = 16'hAAAA;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0; mio_en = 1'b0;
    #1;
    total++; if (r !== 1'b0) begin bad++; $display("FAIL abort_r_now got=%b exp=0", r); end
    r_seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (r === 1'b1) r_seen++;
    end
    total++; if (r_seen != 0) begin bad++; $display("FAIL abort_r_during_reset got=%0d exp=0", r_seen); end
    @(negedge clk); rst_n = 1'b1;
    do_access(1'b0, 16'h0010, 16'h0000, 0);
    total++; if (acc_lat != 3) begin bad++; $display("FAIL abort_next_latency got=%0d exp=3", acc_lat); end
    total++; if (acc_data !== 16'h0000) begin bad++; $display("FAIL abort_no_commit got=%h exp=0000", acc_data); end
  endtask

`ifdef MEMORY_RESPONDER_MMIO_EN
  task automatic test_mmio();
    @(negedge clk); kb_valid = 1'b1; kb_char = 8'h41;
    @(negedge clk); kb_valid = 1'b0; kb_char = 8'h00;
    do_access(1'b0, 16'hFE00, 16'h0000, 0);
    total++; if (acc_data !== 16'h8000) begin bad++; $display("FAIL kbsr_set got=%h exp=8000", acc_data); end
    do_access(1'b0, 16'hFE02, 16'h0000, 0);
    total++; if (acc_data !== 16'h0041) begin bad++; $display("FAIL kbdr_char got=%h exp=0041", acc_data); end
    do_access(1'b0, 16'hFE00, 16'h0000, 0);
    total++; if (acc_data !== 16'h0000) begin bad++; $display("FAIL kbsr_cleared got=%h exp=0000", acc_data); end
    @(negedge clk); kb_valid = 1'b1; kb_char = 8'h43;
    do_access(1'b0, 16'hFE02, 16'h0000, 0);
    kb_valid = 1'b0;
    do_access(1'b0, 16'hFE00, 16'h0000, 0);
    total++; if (acc_data !== 16'h8000) begin bad++; $display("FAIL kbsr_set_wins got=%h exp=8000", acc_data); end
    do_access(1'b1, 16'hFE06, 16'h0048, 0);
    total++; if (acc_dsp_cnt != 1) begin bad++; $display("FAIL dsp_valid_cycles got=%0d exp=1", acc_dsp_cnt); end
    total++; if (acc_dsp_char !== 8'h48) begin bad++; $display("FAIL dsp_char got=%h exp=48", acc_dsp_char); end
    do_access(1'b0, 16'hFE04, 16'h0000, 0);
    total++; if (acc_data !== 16'h8000) begin bad++; $display("FAIL dsr_read got=%h exp=8000", acc_data); end
  endtask
`else
  task automatic test_mmio();
    do_access(1'b1, 16'hFE00, 16'h1111, 0);
    @(negedge clk); kb_valid = 1'b1; kb_char = 8'h41;
    @(negedge clk); kb_valid = 1'b0; kb_char = 8'h00;
    do_access(1'b0, 16'hFE00, 16'h0000, 0);
    total++; if (acc_data !== 16'h1111) begin bad++; $display("FAIL fe00_is_store got=%h exp=1111", acc_data); end
    do_access(1'b1, 16'hFE06, 16'h0048, 0);
    total++; if (acc_dsp_cnt != 0) begin bad++; $display("FAIL dsp_tied_off got=%0d exp=0", acc_dsp_cnt); end
    do_access(1'b0, 16'h0E06, 16'h0000, 0);
    total++; if (acc_data !== 16'h0048) begin bad++; $display("FAIL fe06_alias got=%h exp=0048", acc_data); end
  endtask
`endif

  task automatic test_back_to_back();
    do_access(1'b1, 16'h0FFF, 16'hC0DE, 0);
    do_access(1'b1, 16'h0000, 16'h7E57, 0);
    do_access(1'b0, 16'h0FFF, 16'h0000, 0);
    total++; if (acc_data !== 16'hC0DE) begin bad++; $display("FAIL b2b_top got=%h exp=c0de", acc_data); end
    do_access(1'b0, 16'h0000, 16'h0000, 0);
    total++; if (acc_data !== 16'h7E57) begin bad++; $display("FAIL b2b_zero got=%h exp=7e57", acc_data); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_held_request();
    test_alias();
    test_reset_abort();
    test_mmio();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_responder.md
MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, meaning the word-address width of the internal backing store (2^ADDR_W x 16 bits).
REQ-002 SHALL have parameter LATENCY, default 3, meaning the cycles from request acceptance to R assertion (legal range 1..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous reset, active-low.
REQ-005 SHALL have port mio_en, input, 1 bit: memory access request from the control unit.
REQ-006 SHALL have port r_w, input, 1 bit: 1 means write, 0 means read; sampled with mio_en.
REQ-007 SHALL have port mar, input, 16 bits: word address.
REQ-008 SHALL have port mdr_in, input, 16 bits: write data.
REQ-009 SHALL have port mem_data, output, 16 bits: read data, valid while r=1.
REQ-010 SHALL have port r, output, 1 bit: ready; a single-cycle pulse ending each access.
REQ-011 SHALL have port kb_valid, input, 1 bit, and port kb_char, input, 8 bits: keyboard strobe and character (MMIO build only).
REQ-012 SHALL have port dsp_valid, output, 1 bit, and port dsp_char, output, 8 bits: display strobe and character (MMIO build only).

Function
REQ-013 SHALL implement FSM IDLE -> BUSY -> READY -> DONE -> IDLE.
REQ-014 In IDLE with mio_en=1, SHALL latch mar, mdr_in and r_w, load the latency counter with LATENCY-1, and enter BUSY.
REQ-015 In BUSY, SHALL decrement the counter each cycle and enter READY when it reaches 0; the first r=1 therefore occurs exactly LATENCY cycles after the accepting edge.
REQ-016 In READY, SHALL drive r=1 for exactly one cycle; a write SHALL commit to the store on entry to READY; a read SHALL present mem_data during that cycle.
REQ-017 In DONE, SHALL hold r=0 until mio_en=0, then return to IDLE; a request held high after r SHALL NOT start a second access.
REQ-018 SHALL use address bits mar[ADDR_W-1:0] for the backing store, so higher addresses alias (wrap).
REQ-019 SHALL ignore mar, mdr_in and r_w changes after acceptance; the latched values govern the access.
REQ-020 SHALL drive mem_data=16'h0000 whenever r=0.

Reset
REQ-021 On rst_n=0, SHALL immediately set FSM=IDLE, r=0, mem_data=0, counter=0, KBSR=0, DSR[15]=1 and dsp_valid=0, including mid-access; store contents are undefined.
REQ-022 An access aborted by reset SHALL NOT commit its write.

Configuration
REQ-023 Macro MEMORY_RESPONDER_MMIO_EN, when defined, SHALL decode KBSR xFE00, KBDR xFE02, DSR xFE04 and DDR xFE06 ahead of the store.
REQ-024 With the macro: kb_valid=1 sets KBSR[15] and captures kb_char into KBDR[7:0]; a read of KBDR clears KBSR[15] at READY; kb_valid arriving in the same cycle as that clear SHALL win (KBSR[15] stays 1).
REQ-025 With the macro: a DDR write pulses dsp_valid for one cycle at READY with dsp_char=mdr[7:0]; DSR[15] reads constant 1.
REQ-026 Without the macro: the xFE00..xFE06 addresses SHALL access the store (aliased); kb_* SHALL be ignored; dsp_valid and dsp_char SHALL be tied to 0.

Structure
REQ-027 SHALL place the FSM state encoding and the MMIO address constants (KBSR_ADDR, KBDR_ADDR, DSR_ADDR, DDR_ADDR) in shared package lc3_pkg.
REQ-028 SHALL have one sub-module, mem_array, a synchronous single-port 16-bit RAM of depth 2^ADDR_W.

Verification
REQ-029 Write x1234 to x0005, then read x0005 with LATENCY=3 -> r pulses 3 cycles after each accept; the read returns mem_data=x1234.
REQ-030 Hold mio_en=1 for 10 cycles on a write -> exactly one r pulse and one commit; no second access until mio_en=0.
REQ-031 Write xBEEF to x1005 with ADDR_W=12 -> a read of x0005 returns xBEEF.
REQ-032 Drop rst_n in BUSY of a write of xAAAA to x0010 -> r stays 0; a later read of x0010 does not return xAAAA (the location is preloaded with x0000 first).
REQ-033 MMIO build, kb_valid with kb_char=x41 -> a KBSR read returns x8000 and a KBDR read returns x0041, after which KBSR reads x0000.
REQ-034 MMIO build, write x0048 to xFE06 -> dsp_valid=1 for one cycle with dsp_char=x48; a DSR read returns x8000.
